id_issue_queue: RTL

- Parametrised successor to the single-entry decode/issue pipeline register.
- A DEPTH-entry FIFO of decoded scoreboard entries sits between the decoder and the issue stage.
- Presents up to ISSUE_W oldest entries per cycle, so dual-issue is possible.
- Supports flush, and a decoder "hold" used by macro-op sequencing: an entry is pushed but the fetch slot is not consumed.

---
 rtl/id_issue_queue_if.sv | 43 ++++
 rtl/id_issue_queue.sv | 129 ++++++++++++
 2 files changed

// File: rtl/id_issue_queue_if.sv
// ============================================================================
// id_issue_queue_if : decoder/issue-side signal bundle for id_issue_queue
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_issue_queue_if #(
  parameter int SBE_W   = 128,
  parameter int DEPTH   = 4,
  parameter int ISSUE_W = 1
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                     flush_i;
  logic                     fetch_entry_valid_i;
  logic                     fetch_entry_ready_o;
  logic                     hold_fetch_i;
  logic [SBE_W-1:0]         sbe_i;
  logic [31:0]              orig_instr_i;
  logic                     is_ctrl_flow_i;
  logic [ISSUE_W*SBE_W-1:0] issue_entry_o;
  logic [ISSUE_W*32-1:0]    orig_instr_o;
  logic [ISSUE_W-1:0]       is_ctrl_flow_o;
  logic [ISSUE_W-1:0]       issue_entry_valid_o;
  logic [ISSUE_W-1:0]       issue_instr_ack_i;
  logic [CNT_W-1:0]         count_o;

  modport master (
    output flush_i, fetch_entry_valid_i, hold_fetch_i, sbe_i, orig_instr_i,
           is_ctrl_flow_i, issue_instr_ack_i,
    input  fetch_entry_ready_o, issue_entry_o, orig_instr_o, is_ctrl_flow_o,
           issue_entry_valid_o, count_o
  );

  modport slave (
    input  flush_i, fetch_entry_valid_i, hold_fetch_i, sbe_i, orig_instr_i,
           is_ctrl_flow_i, issue_instr_ack_i,
    output fetch_entry_ready_o, issue_entry_o, orig_instr_o, is_ctrl_flow_o,
           issue_entry_valid_o, count_o
  );
endinterface

`default_nettype wire

// File: rtl/id_issue_queue.sv
// ============================================================================
// id_issue_queue : DEPTH-entry decode/issue FIFO presenting ISSUE_W oldest
// entries per cycle. Optional same-cycle bypass: ID_ISSUE_QUEUE_BYPASS_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module id_issue_queue #(
  parameter int SBE_W   = 128,
  parameter int DEPTH   = 4,
  parameter int ISSUE_W = 1,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_issue_queue_if.slave q_if
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [SBE_W-1:0] sbe_q   [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic             cf_q    [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0] npop;
  logic       push;
  logic       bypass_take;
  logic       write_en;

  // DEPTH need not be a power of two, so wrap explicitly
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  logic [SBE_W-1:0] head_sbe;
  logic [31:0]      head_instr;
  logic             head_cf;
  logic             head_valid;

`ifdef ID_ISSUE_QUEUE_BYPASS_EN
  logic bypass_show;
  assign bypass_show = (count_q == '0) && q_if.fetch_entry_valid_i && !q_if.flush_i;
  assign bypass_take = bypass_show && q_if.issue_instr_ack_i[0];
  assign head_sbe    = bypass_show ? q_if.sbe_i          : sbe_q[rd_ptr_q];
  assign head_instr  = bypass_show ? q_if.orig_instr_i   : instr_q[rd_ptr_q];
  assign head_cf     = bypass_show ? q_if.is_ctrl_flow_i : cf_q[rd_ptr_q];
  assign head_valid  = bypass_show || (count_q != '0);
`else
  assign bypass_take = 1'b0;
  assign head_sbe    = sbe_q[rd_ptr_q];
  assign head_instr  = instr_q[rd_ptr_q];
  assign head_cf     = cf_q[rd_ptr_q];
  assign head_valid  = (count_q != '0);
`endif

  always_comb begin
    npop = 2'd0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (q_if.issue_instr_ack_i[k] && (int'(count_q) > k)) npop = npop + 2'd1;
    end

    push = q_if.fetch_entry_valid_i && !q_if.flush_i && !rst_i &&
           ((int'(count_q) - int'(npop)) < DEPTH);
    write_en = push && !bypass_take;

    rd_ptr_d = ptr_add(rd_ptr_q, int'(npop));
    wr_ptr_d = write_en ? ptr_add(wr_ptr_q, 1) : wr_ptr_q;
    count_d  = CNT_W'(int'(count_q) - int'(npop) + (write_en ? 1 : 0));

    // Acks during flush were already issued downstream; only the reset matters
    if (q_if.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  assign q_if.fetch_entry_ready_o = push && !q_if.hold_fetch_i;
  assign q_if.count_o             = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sbe_q[i]   <= '0;
        instr_q[i] <= '0;
        cf_q[i]    <= 1'b0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (write_en) begin
        sbe_q[wr_ptr_q]   <= q_if.sbe_i;
        instr_q[wr_ptr_q] <= q_if.orig_instr_i;
        cf_q[wr_ptr_q]    <= q_if.is_ctrl_flow_i;
      end
    end
  end

  generate
    for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
      if (k == 0) begin : g_head
        assign q_if.issue_entry_o[SBE_W-1:0] = head_sbe;
        assign q_if.orig_instr_o[31:0]       = head_instr;
        assign q_if.is_ctrl_flow_o[0]        = head_cf;
        assign q_if.issue_entry_valid_o[0]   = head_valid;
      end else begin : g_tail
        logic [PTR_W-1:0] idx;
        assign idx = ptr_add(rd_ptr_q, k);
        assign q_if.issue_entry_o[k*SBE_W +: SBE_W] = sbe_q[idx];
        assign q_if.orig_instr_o[k*32 +: 32]        = instr_q[idx];
        assign q_if.is_ctrl_flow_o[k]               = cf_q[idx];
        assign q_if.issue_entry_valid_o[k]          = (int'(count_q) > k);
      end
    end
  endgenerate

endmodule

`default_nettype wire
